// File: rtl/sonar_echo_timer_pkg.sv
// sonar_pkg: shared state encoding and default timing constants for the
// ultrasonic trigger-and-capture engine.
package sonar_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRIG      = 2'd1,
    WAIT_RISE = 2'd2,
    MEASURE   = 2'd3
  } state_t;

  // Defaults for a 50 MHz system clock and a typical HC-SR04 style sensor
  localparam int unsigned DEF_CLKS_PER_US = 50;
  localparam int unsigned DEF_TRIG_US     = 10;
  localparam int unsigned DEF_TIMEOUT_US  = 30000;
  localparam int unsigned DEF_WIDTH       = 32;

endpackage

// File: rtl/sonar_echo_timer_if.sv
// sonar_echo_timer_if: bundles the request/result signals and the dedicated
// trig/echo pins. The master side requests measurements and drives the echo
// pin; the slave side is the timer itself.
interface sonar_echo_timer_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic             echo;
  logic             trig;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [WIDTH-1:0] width_us;

  modport master (
    output start, echo,
    input  trig, busy, done, timeout, width_us
  );

  modport slave (
    input  start, echo,
    output trig, busy, done, timeout, width_us
  );
endinterface

// File: rtl/sonar_echo_timer_echo_sync.sv
// echo_sync: two-flop synchronizer for the asynchronous echo pin.
// Only instantiated when ECHO_SYNC_EN is defined.
module echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);
  logic r_meta;
  logic r_sync;

  // Two-stage capture; the first flop may go metastable, the second settles it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;
endmodule

// File: rtl/sonar_echo_timer.sv
// sonar_echo_timer: drives a fixed-length trigger pulse, waits for the echo
// and measures its high width in whole microseconds via a prescaled clock.
// Optional feature macro: ECHO_SYNC_EN (adds a two-flop echo synchronizer,
// delaying every echo-relative event by two cycles).
module sonar_echo_timer
  import sonar_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = DEF_CLKS_PER_US,
  parameter int unsigned TRIG_US     = DEF_TRIG_US,
  parameter int unsigned TIMEOUT_US  = DEF_TIMEOUT_US,
  parameter int unsigned WIDTH       = DEF_WIDTH
) (
  input logic              clk,
  input logic              reset,
  sonar_echo_timer_if.slave bus
);

  localparam int unsigned      PRE_W       = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLKS_PER_US - 1);
  localparam logic [WIDTH-1:0] TRIG_LAST   = WIDTH'(TRIG_US - 1);
  localparam logic [WIDTH-1:0] CNT_TIMEOUT = WIDTH'(TIMEOUT_US);

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [WIDTH-1:0] r_cnt;
  logic             r_trig;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic [WIDTH-1:0] r_width;

  logic             w_echo_s;
  logic             w_pre_wrap;
  logic [PRE_W-1:0] w_pre_next;
  logic [WIDTH-1:0] w_cnt_next;

`ifdef ECHO_SYNC_EN
  echo_sync u_echo_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.echo),
    .o_sync  (w_echo_s)
  );
`else
  assign w_echo_s = bus.echo;
`endif

  // The prescaler and microsecond counter share one advance rule in every
  // counting state: pre wraps at CLKS_PER_US-1 and carries into cnt.
  assign w_pre_wrap = (r_pre == PRE_LAST);
  assign w_pre_next = w_pre_wrap ? '0 : r_pre + PRE_W'(1);
  assign w_cnt_next = w_pre_wrap ? r_cnt + WIDTH'(1) : r_cnt;

  // Measurement sequencer with all outputs registered. Timeout compares use
  // the registered cnt, so a falling (or rising) echo seen on the same cycle
  // takes priority over the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_cnt     <= '0;
      r_trig    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_width   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= TRIG;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_trig  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        TRIG: begin
          if (w_pre_wrap && (r_cnt == TRIG_LAST)) begin
            r_state <= WAIT_RISE;
            r_trig  <= 1'b0;
            r_pre   <= '0;
            r_cnt   <= '0;
          end else begin
            r_pre <= w_pre_next;
            r_cnt <= w_cnt_next;
          end
        end
        WAIT_RISE: begin
          if (w_echo_s) begin
            r_state <= MEASURE;
            r_pre   <= PRE_W'(1);
            r_cnt   <= '0;
          end else if (r_cnt == CNT_TIMEOUT) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_width   <= '0;
          end else begin
            r_pre <= w_pre_next;
            r_cnt <= w_cnt_next;
          end
        end
        MEASURE: begin
          if (!w_echo_s) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
            r_width   <= r_cnt;
          end else if (r_cnt == CNT_TIMEOUT) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_width   <= CNT_TIMEOUT;
          end else begin
            r_pre <= w_pre_next;
            r_cnt <= w_cnt_next;
          end
        end
        default: begin
          r_state <= IDLE;
          r_trig  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trig     = r_trig;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.timeout  = r_timeout;
  assign bus.width_us = r_width;

endmodule
